// File: rtl/lz77_match_engine_if.sv
// Start, window-RAM, token and slide signals between the match engine and its neighbours.
interface lz77_match_engine_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AW     = 6;
  localparam int unsigned LA_LEN = 8;
  localparam int unsigned LW     = 4;

  logic                     start;
  logic [AW:0]              win_fill;
  logic [LA_LEN*DATA_W-1:0] la_data;
  logic [LW-1:0]            la_cnt;
  logic [AW-1:0]            win_addr;
  logic [DATA_W-1:0]        win_data;
  logic                     tok_valid;
  logic                     tok_ready;
  logic [AW:0]              tok_offset;
  logic [LW-1:0]            tok_len;
  logic [DATA_W-1:0]        tok_char;
  logic                     sliding;
  logic [LW-1:0]            slide_n;
  logic                     slide_done;
  logic                     busy;

  // Match engine side
  modport master (
    input  start, win_fill, la_data, la_cnt, win_data, tok_ready, slide_done,
    output win_addr, tok_valid, tok_offset, tok_len, tok_char, sliding, slide_n, busy
  );

  // RAM control / encoder side
  modport slave (
    output start, win_fill, la_data, la_cnt, win_data, tok_ready, slide_done,
    input  win_addr, tok_valid, tok_offset, tok_len, tok_char, sliding, slide_n, busy
  );
endinterface

// File: rtl/lz77_match_engine.sv
// LZ77 longest-match engine: streams the search window one byte per cycle through a
// shift-compare array, emits one (offset, length, literal) token, then requests a slide.
// Build macro LZ_MIN_MATCH_EN: matches shorter than MIN_MATCH are emitted as a plain literal.
module lz77_match_engine (
  input  logic                 Clk,
  input  logic                 Rst,
  lz77_match_engine_if.master  bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WIN_D  = 64;
  localparam int unsigned AW     = $clog2(WIN_D);
  localparam int unsigned FW     = AW + 1;
  localparam int unsigned LA_LEN = 8;
  localparam int unsigned LW     = 4;
  localparam int unsigned LIW    = $clog2(LA_LEN);
`ifdef LZ_MIN_MATCH_EN
  localparam int unsigned MIN_MATCH = 3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_SLIDE} state_t;

  state_t                   state_q, state_d;
  logic [LA_LEN*DATA_W-1:0] la_q, la_d;
  logic [LW-1:0]            cnt_q, cnt_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     vld_q, vld_d;
  logic [AW-1:0]            pos_q, pos_d;
  logic [LA_LEN-2:0]        m_q, m_d;
  logic [LW-1:0]            best_len_q, best_len_d;
  logic [AW-1:0]            best_pos_q, best_pos_d;
  logic                     tok_valid_q, tok_valid_d;
  logic [FW-1:0]            tok_offset_q, tok_offset_d;
  logic [LW-1:0]            tok_len_q, tok_len_d;
  logic [DATA_W-1:0]        tok_char_q, tok_char_d;
  logic                     sliding_q, sliding_d;
  logic [LW-1:0]            slide_n_q, slide_n_d;
  logic                     busy_q, busy_d;

  logic [DATA_W-1:0]        la_b [LA_LEN];
  logic [LA_LEN-1:0]        m_n;
  logic                     last;
  logic [LW-1:0]            cand_len;
  logic [AW-1:0]            cand_pos;
  logic [LW-1:0]            fin_len;

  // Unpack the latched lookahead into bytes
  always_comb begin
    for (int k = 0; k < LA_LEN; k++) begin
      la_b[k] = la_q[k*DATA_W +: DATA_W];
    end
  end

  // Shift-compare array: m_n[k] means the window bytes ending here match la[0..k]
  always_comb begin
    m_n    = '0;
    m_n[0] = (cnt_q > LW'(1)) && (bus.win_data == la_b[0]);
    for (int k = 1; k < LA_LEN - 1; k++) begin
      if ((LW'(k) + LW'(1)) < cnt_q) begin
        m_n[k] = m_q[k-1] && (bus.win_data == la_b[k]);
      end
    end
  end

  // Fold every candidate ending at this byte into the best match; later starts win ties
  always_comb begin
    cand_len = best_len_q;
    cand_pos = best_pos_q;
    last     = vld_q && ({1'b0, pos_q} == (fill_q - FW'(1)));
    // Candidates that stopped matching here, ordered by ascending start
    for (int k = LA_LEN - 1; k >= 1; k--) begin
      if (m_q[k-1] && !m_n[k] && (LW'(k) >= cand_len)) begin
        cand_len = LW'(k);
        cand_pos = pos_q - AW'(k);
      end
    end
    // On the last window byte every live candidate ends; they start after the ones above
    if (last) begin
      for (int k = LA_LEN - 2; k >= 0; k--) begin
        if (m_n[k] && (LW'(k + 1) >= cand_len)) begin
          cand_len = LW'(k + 1);
          cand_pos = pos_q - AW'(k);
        end
      end
    end
    fin_len = cand_len;
`ifdef LZ_MIN_MATCH_EN
    if (cand_len < LW'(MIN_MATCH)) begin
      fin_len = '0;
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    la_d         = la_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    addr_d       = addr_q;
    vld_d        = vld_q;
    pos_d        = pos_q;
    m_d          = m_q;
    best_len_d   = best_len_q;
    best_pos_d   = best_pos_q;
    tok_valid_d  = tok_valid_q;
    tok_offset_d = tok_offset_q;
    tok_len_d    = tok_len_q;
    tok_char_d   = tok_char_q;
    sliding_d    = sliding_q;
    slide_n_d    = slide_n_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          la_d       = bus.la_data;
          cnt_d      = bus.la_cnt;
          fill_d     = bus.win_fill;
          m_d        = '0;
          best_len_d = '0;
          best_pos_d = '0;
          addr_d     = '0;
          vld_d      = 1'b0;
          pos_d      = '0;
          if (bus.win_fill == '0) begin
            state_d      = S_EMIT;
            tok_valid_d  = 1'b1;
            tok_len_d    = '0;
            tok_offset_d = '0;
            tok_char_d   = bus.la_data[DATA_W-1:0];
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if ({1'b0, addr_q} < (fill_q - FW'(1))) begin
          addr_d = addr_q + AW'(1);
        end
        vld_d = 1'b1;
        pos_d = addr_q;
        if (vld_q) begin
          m_d        = m_n[LA_LEN-2:0];
          best_len_d = cand_len;
          best_pos_d = cand_pos;
        end
        if (last) begin
          state_d      = S_EMIT;
          tok_valid_d  = 1'b1;
          tok_len_d    = fin_len;
          tok_offset_d = (fin_len != '0) ? (fill_q - {1'b0, cand_pos}) : '0;
          tok_char_d   = la_b[fin_len[LIW-1:0]];
        end
      end
      S_EMIT: begin
        if (bus.tok_ready) begin
          state_d     = S_SLIDE;
          tok_valid_d = 1'b0;
          sliding_d   = 1'b1;
          slide_n_d   = tok_len_q + LW'(1);
        end
      end
      S_SLIDE: begin
        if (bus.slide_done) begin
          state_d   = S_IDLE;
          sliding_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      la_q         <= '0;
      cnt_q        <= '0;
      fill_q       <= '0;
      addr_q       <= '0;
      vld_q        <= 1'b0;
      pos_q        <= '0;
      m_q          <= '0;
      best_len_q   <= '0;
      best_pos_q   <= '0;
      tok_valid_q  <= 1'b0;
      tok_offset_q <= '0;
      tok_len_q    <= '0;
      tok_char_q   <= '0;
      sliding_q    <= 1'b0;
      slide_n_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      la_q         <= la_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      addr_q       <= addr_d;
      vld_q        <= vld_d;
      pos_q        <= pos_d;
      m_q          <= m_d;
      best_len_q   <= best_len_d;
      best_pos_q   <= best_pos_d;
      tok_valid_q  <= tok_valid_d;
      tok_offset_q <= tok_offset_d;
      tok_len_q    <= tok_len_d;
      tok_char_q   <= tok_char_d;
      sliding_q    <= sliding_d;
      slide_n_q    <= slide_n_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.win_addr   = addr_q;
  assign bus.tok_valid  = tok_valid_q;
  assign bus.tok_offset = tok_offset_q;
  assign bus.tok_len    = tok_len_q;
  assign bus.tok_char   = tok_char_q;
  assign bus.sliding    = sliding_q;
  assign bus.slide_n    = slide_n_q;
  assign bus.busy       = busy_q;
endmodule
